// File: rtl/alarm_sequencer.sv
// Alarm control stage: detects the alarm minute, rings for a bounded time,
// and handles debounced snooze and arm/disarm switches.
module alarm_sequencer #(
  parameter int unsigned RING_SECONDS    = 60,
  parameter int unsigned SNOOZE_SECONDS  = 300,
  parameter int unsigned MAX_SNOOZE      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_SW,
  input  logic       sec_tick,
  input  logic [3:0] minutes_ones,
  input  logic [2:0] minutes_tens,
  input  logic [3:0] seconds_ones,
  input  logic [2:0] seconds_tens,
  input  logic [3:0] load_minutes_ones,
  input  logic [2:0] load_minutes_tens,
  input  logic       load_SW,
  input  logic       alarm_off_SW,
  input  logic       snooze_BTN,
  output logic       play_sound,
  output logic       snooze_active,
  output logic [1:0] snooze_count,
  output logic [1:0] alarm_state
);

  localparam int unsigned RW = (RING_SECONDS > 1)    ? $clog2(RING_SECONDS)    : 1;
  localparam int unsigned SW = (SNOOZE_SECONDS > 1)  ? $clog2(SNOOZE_SECONDS)  : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SECONDS - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    SNZ_MAX     = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   ring_t, ring_n;
  logic [SW-1:0]   snz_t, snz_n;
  logic [1:0]      cnt_n;
  logic            match, match_prev, trigger;

  logic [1:0]      sync_q;
  logic [DW-1:0]   db_cnt;
  logic            stable, stable_d, snooze_press;

  assign match = (minutes_ones == load_minutes_ones) &&
                 (minutes_tens == load_minutes_tens) &&
                 (seconds_ones == 4'd0) && (seconds_tens == 3'd0);
  assign trigger     = match & ~match_prev;
  assign alarm_state = state;

  // Synchronizer, debounce counter and registered rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset_SW) begin
      sync_q       <= '0;
      db_cnt       <= '0;
      stable       <= 1'b0;
      stable_d     <= 1'b0;
      snooze_press <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], snooze_BTN};
      if (sync_q[1] != stable) begin
        if (db_cnt == DEB_LAST) begin
          stable <= sync_q[1];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
      stable_d     <= stable;
      snooze_press <= stable & ~stable_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_SW) begin
      state         <= DISARMED;
      ring_t        <= '0;
      snz_t         <= '0;
      snooze_count  <= '0;
      match_prev    <= 1'b0;
      play_sound    <= 1'b0;
      snooze_active <= 1'b0;
    end else begin
      state         <= state_n;
      ring_t        <= ring_n;
      snz_t         <= snz_n;
      snooze_count  <= cnt_n;
      match_prev    <= match;
      play_sound    <= (state_n == RINGING);
      snooze_active <= (state_n == SNOOZE);
    end
  end

  always_comb begin
    state_n = state;
    ring_n  = ring_t;
    snz_n   = snz_t;
    cnt_n   = snooze_count;
    if (load_SW || alarm_off_SW) begin
      state_n = DISARMED;
      ring_n  = '0;
      snz_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        DISARMED: state_n = ARMED;
        ARMED: begin
          if (trigger) begin
            state_n = RINGING;
            ring_n  = '0;
            cnt_n   = '0;
          end
        end
        RINGING: begin
          // A press in the same cycle as the final tick takes precedence.
          if (snooze_press && (snooze_count < SNZ_MAX)) begin
            state_n = SNOOZE;
            cnt_n   = snooze_count + 1'b1;
            snz_n   = '0;
          end else if (sec_tick) begin
            if (ring_t == RING_LAST) begin
              state_n = ARMED;
              cnt_n   = '0;
            end else begin
              ring_n = ring_t + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (sec_tick) begin
            if (snz_t == SNOOZE_LAST) begin
              state_n = RINGING;
              ring_n  = '0;
            end else begin
              snz_n = snz_t + 1'b1;
            end
          end
        end
        default: state_n = DISARMED;
      endcase
    end
  end

endmodule
